// File: rtl/or4_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : or4_arb_pkg
// Purpose : Shared constants for the or4_arbiter block: FSM state codes and
//           default requester count / datapath width.
// Rev     : 1.0  initial release
// ============================================================================
package or4_arb_pkg;

  // FSM state encoding (IDLE -> EXEC -> DONE -> IDLE)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default configuration
  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 4;

endpackage : or4_arb_pkg
`default_nettype wire

// File: rtl/or4.sv
`default_nettype none
// ============================================================================
// Module  : or4
// Purpose : Shared 4-bit bitwise OR unit, y = a | b.
// Rev     : 1.0  initial release
// ============================================================================
module or4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  assign y = a | b;

endmodule : or4
`default_nettype wire

// File: rtl/or4_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : or4_arbiter
// Purpose : Round-robin arbiter giving N_REQ requesters turns on a single
//           shared or4 unit. Each operation takes three cycles
//           (IDLE -> EXEC -> DONE) and finishes with a one-cycle done pulse.
// Rev     : 1.0  initial release
// ============================================================================
module or4_arbiter
  import or4_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,  // 2..8
  parameter int W     = DEF_W       // must stay 4 to match the or4 unit
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       y,
  output logic               busy
);

  localparam int              PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q,   ptr_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [N_REQ-1:0] done_q,  done_d;
  logic [W-1:0]     y_q,     y_d;
  logic [W-1:0]     op_a_q,  op_a_d;
  logic [W-1:0]     op_b_q,  op_b_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand_idx;
  int               cand_int;
  logic [W-1:0]     or_y;

  // The only OR logic in the block: operates on the latched operands so
  // input changes after the grant cannot disturb the operation in flight.
  or4 u_or4 (
    .a (op_a_q),
    .b (op_b_q),
    .y (or_y)
  );

  // Round-robin search: first pending request at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_int  = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_int = (int'(ptr_q) + k) % N_REQ;
      cand_idx = cand_int[PTR_W-1:0];
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and output-register logic of the three-state FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    y_d     = y_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        done_d = '0;
        if (win_found) begin
          state_d        = ST_EXEC;
          gnt_d[win_idx] = 1'b1;
          op_a_d         = a_in[win_idx*W +: W];
          op_b_d         = b_in[win_idx*W +: W];
          ptr_d          = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        done_d  = gnt_q;
        y_d     = or_y;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        done_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        done_d  = '0;
      end
    endcase
  end

  // State registers; reset abandons any operation without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      y_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      y_q     <= y_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign y    = y_q;
  assign busy = (state_q != ST_IDLE);

endmodule : or4_arbiter
`default_nettype wire

// File: tb/tb_or4_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_or4_arbiter
// Purpose : Self-checking bench for or4_arbiter with a transaction-level
//           reference model (round-robin pick, a|b result, 3-cycle slot).
// Rev     : 1.0  initial release
// ============================================================================
module tb_or4_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   y;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           m_ptr;
  int           m_phase;   // cycles into current operation: 0 idle, 1 granted, 2 completing
  int           m_win;
  logic [N-1:0] m_gnt;
  logic [N-1:0] m_done;
  logic [W-1:0] m_y;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;

  always #5 clk = ~clk;

  or4_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .gnt   (gnt),
    .done  (done),
    .y     (y),
    .busy  (busy)
  );

  task automatic model_reset();
    m_ptr = 0; m_phase = 0; m_win = 0;
    m_gnt = '0; m_done = '0; m_y = '0; m_a = '0; m_b = '0;
  endtask

  // Predict the effect of the coming rising edge from the inputs now applied.
  task automatic model_tick();
    bit found;
    if (!rst_n) begin
      model_reset();
    end else if (m_phase == 0) begin
      m_done = '0;
      m_gnt  = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found = 1'b1;
          m_win = idx;
        end
      end
      if (found) begin
        m_gnt        = '0;
        m_gnt[m_win] = 1'b1;
        m_a          = a_in[m_win*W +: W];
        m_b          = b_in[m_win*W +: W];
        m_ptr        = (m_win + 1) % N;
        m_phase      = 1;
      end
    end else if (m_phase == 1) begin
      m_done  = m_gnt;
      m_y     = m_a | m_b;
      m_phase = 2;
    end else begin
      m_gnt   = '0;
      m_done  = '0;
      m_phase = 0;
    end
  endtask

  task automatic cyc();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < 4 && m_phase != 0; i++) cyc();
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
    repeat (3) cyc();
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", done); end
    n_tests++; if (y !== 4'b0000) begin n_fail++; $display("FAIL reset_y: got %b expected 0000", y); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    cyc();
    n_tests++; if (gnt !== 4'b0001 || gnt !== m_gnt) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
    drain();
  endtask

  task automatic test_single();
    logic [N-1:0] eg [4];
    logic [N-1:0] ed [4];
    eg[0] = 4'b0100; eg[1] = 4'b0100; eg[2] = 4'b0000; eg[3] = 4'b0000;
    ed[0] = 4'b0000; ed[1] = 4'b0100; ed[2] = 4'b0000; ed[3] = 4'b0000;
    a_in = '0; b_in = '0;
    a_in[11:8] = 4'b1010;
    b_in[11:8] = 4'b0101;
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) req = '0;
      n_tests++; if (gnt !== eg[i]) begin n_fail++; $display("FAIL single_gnt c%0d: got %b expected %b", i, gnt, eg[i]); end
      n_tests++; if (done !== ed[i]) begin n_fail++; $display("FAIL single_done c%0d: got %b expected %b", i, done, ed[i]); end
      n_tests++; if (busy !== (i < 2)) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", i, busy, (i < 2)); end
      if (i == 1) begin
        n_tests++; if (y !== 4'b1111) begin n_fail++; $display("FAIL single_y: got %b expected 1111", y); end
      end
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [8];
    logic [N-1:0] exp_seq [5];
    logic [N-1:0] prev;
    int ng, nd;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    a_in = 16'($urandom); b_in = 16'($urandom);
    req = 4'b1111;
    ng = 0; nd = 0; prev = '0;
    for (int c = 0; c < 15; c++) begin
      cyc();
      n_tests++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, m_gnt); end
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rr_done c%0d: got %b expected %b", c, done, m_done); end
      n_tests++; if (y !== m_y) begin n_fail++; $display("FAIL rr_y c%0d: got %b expected %b", c, y, m_y); end
      if (gnt !== '0 && prev === '0 && ng < 8) begin seq[ng] = gnt; ng++; end
      if (done !== '0) nd++;
      prev = gnt;
    end
    n_tests++; if (ng != 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", ng); end
    n_tests++; if (nd != 5) begin n_fail++; $display("FAIL rr_done_count: got %0d expected 5", nd); end
    for (int i = 0; i < 5 && i < ng; i++) begin
      n_tests++; if (seq[i] !== exp_seq[i]) begin n_fail++; $display("FAIL rr_order #%0d: got %b expected %b", i, seq[i], exp_seq[i]); end
    end
    drain();
  endtask

  task automatic test_operand_stability();
    a_in = 16'($urandom); b_in = 16'($urandom);
    a_in[7:4] = 4'b1100;
    b_in[7:4] = 4'b0110;
    req = 4'b0010;
    cyc();
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL stab_gnt: got %b expected 0010", gnt); end
    a_in = '0;
    req  = '0;
    cyc();
    n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL stab_done: got %b expected 0010", done); end
    n_tests++; if (y !== 4'b1110 || y !== m_y) begin n_fail++; $display("FAIL stab_y: got %b expected 1110", y); end
    drain();
  endtask

  task automatic test_mid_reset();
    a_in = 16'hFFFF; b_in = 16'h0000;
    req = 4'b0010;
    cyc();
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mrst_pre_gnt: got %b expected 0010", gnt); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mrst_gnt: got %b expected 0000", gnt); end
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL mrst_done: got %b expected 0000", done); end
    n_tests++; if (y !== 4'b0000) begin n_fail++; $display("FAIL mrst_y: got %b expected 0000", y); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b expected 0", busy); end
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL mrst_no_done c%0d: got %b expected 0000", i, done); end
    end
    rst_n = 1'b1;
    cyc();
    n_tests++; if (gnt !== 4'b0001 || gnt !== m_gnt) begin n_fail++; $display("FAIL mrst_ptr0_gnt: got %b expected 0001", gnt); end
    drain();
  endtask

  task automatic test_zero();
    a_in = '0; b_in = '0;
    a_in[3:0] = 4'b1111;
    req = 4'b0001;
    cyc();
    req = '0;
    cyc();
    n_tests++; if (y !== 4'b1111) begin n_fail++; $display("FAIL zero_prev_y: got %b expected 1111", y); end
    drain();
    a_in = '0; b_in = '0;
    req = 4'b1000;
    cyc();
    req = '0;
    cyc();
    n_tests++; if (done !== 4'b1000) begin n_fail++; $display("FAIL zero_done: got %b expected 1000", done); end
    n_tests++; if (y !== 4'b0000) begin n_fail++; $display("FAIL zero_y: got %b expected 0000", y); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req  = 4'($urandom_range(0, 15));
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      cyc();
      n_tests++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, gnt, m_gnt); end
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rand_done c%0d: got %b expected %b", c, done, m_done); end
      n_tests++; if (y !== m_y) begin n_fail++; $display("FAIL rand_y c%0d: got %b expected %b", c, y, m_y); end
      n_tests++; if (busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, (m_phase != 0)); end
      n_tests++; if ($countones(gnt) > 1 || (done & ~gnt) !== '0) begin n_fail++; $display("FAIL rand_onehot c%0d: got gnt %b done %b expected one-hot, done within gnt", c, gnt, done); end
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_operand_stability();
    test_mid_reset();
    test_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_or4_arbiter
`default_nettype wire

// File: doc/or4_arbiter.md
OR4_ARBITER -- requirements
Module: or4_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 4-bit OR unit; legal range 2..8.
REQ-002 Parameter W, default 4, operand/result width; fixed at 4 to match the shared or4 unit.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  N_REQ  request per requester; high = operation pending.
REQ-006 a_in  input  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
REQ-007 b_in  input  N_REQ*W  operand B; same packing as a_in.
REQ-008 gnt  output  N_REQ  registered one-hot grant; all-zero when idle.
REQ-009 done  output  N_REQ  registered one-hot, one-cycle completion pulse.
REQ-010 y  output  W  registered result of the most recently completed operation.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC, DONE; the only transitions are IDLE->EXEC, EXEC->DONE and DONE->IDLE.
REQ-013 In IDLE with req all-zero, the FSM SHALL stay in IDLE with gnt=0 and done=0.
REQ-014 In IDLE with any req bit high, the winner SHALL be the first set bit searched upward from ptr, wrapping from N_REQ-1 to 0.
REQ-015 On the IDLE->EXEC edge, the block SHALL set gnt[winner]=1, latch the winner's a and b slices into op_a/op_b, and set ptr=(winner+1) mod N_REQ.
REQ-016 On the EXEC->DONE edge, the block SHALL load y <= op_a | op_b (via the or4 instance) and set done[winner]=1.
REQ-017 On the DONE->IDLE edge, the block SHALL clear gnt and done; y SHALL hold its value until the next EXEC->DONE edge.
REQ-018 Latency: req sampled at edge k gives gnt high from edge k, and done plus a valid y from edge k+1 for one cycle; at most one operation completes every 3 cycles.
REQ-019 Operand or req changes after the grant edge SHALL NOT affect the operation in flight; dropping req mid-operation SHALL NOT abort it.
REQ-020 A req bit still high in IDLE after its done pulse SHALL count as a new request and compete under round-robin.
REQ-021 Requests arriving in the same cycle SHALL be resolved only by the ptr order; no requester SHALL wait more than N_REQ-1 operations while holding req.
REQ-022 gnt and done SHALL never have more than one bit set, and done[i] SHALL only be set while gnt[i] is set.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state=IDLE, gnt=0, done=0, y=0, busy=0, ptr=0 and op_a=op_b=0.
REQ-024 Reset during EXEC or DONE SHALL abandon the operation with no done pulse; the first request after release SHALL be arbitrated from ptr=0.
REQ-025 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-026 A shared package or4_arb_pkg SHALL hold the state enumeration (IDLE, EXEC, DONE) and the default N_REQ and W constants.
REQ-027 The datapath SHALL be exactly one instance of the existing or4 module (ports a, b, y) fed by op_a/op_b; no other OR logic is permitted.
REQ-028 The round-robin priority search SHALL stay inside or4_arbiter; no further sub-modules.

Verification
REQ-029 Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, done=0, y=0000, busy=0; after release, the first grant goes to requester 0.
REQ-030 Single request: req=4'b0100, slot2 a=1010 b=0101 -> gnt=0100 for 2 cycles, done=0100 for 1 cycle with y=1111, then IDLE.
REQ-031 Round-robin: req=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, with a done between each grant.
REQ-032 Operand stability: slot1 a=1100 b=0110 granted, then a_in changed to 0000 in EXEC -> y=1110.
REQ-033 Mid-operation reset: assert rst_n low during EXEC -> no done pulse; all outputs 0; the next request is served from ptr=0.
REQ-034 Zero operands: slot3 a=0000 b=0000 -> done=1000 and y=0000; a previous y of 1111 SHALL be overwritten.
